multicycle_controller: RTL
==========================

# multicycle_controller

Moore-style main control FSM for the 32-bit multicycle MIPS datapath. It sequences instruction fetch, register decode, execute, memory access and write-back over several cycles, and drives every datapath mux select and write enable. Its `aluOp` output feeds the existing ALU decoder, which combines it with `funct` to form `aluControl`. A single-bit memory-ready handshake stretches the memory-access states.

## Interface
- No parameters; opcodes and state encodings are fixed constants in the package.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: instr[31:26], taken from the instruction register.
- `zero` in 1: ALU zero flag.
- `memReady` in 1: memory completes the current access this cycle.
- `memReq` out 1: memory access request.
- `iorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memWrite` out 1: memory write strobe.
- `irWrite` out 1: instruction register load.
- `regDst` out 1: write register select, 0 = rt, 1 = rd.
- `memToReg` out 1: write data select, 0 = ALUOut, 1 = MDR.
- `regWrite` out 1: register file write.
- `aluSrcA` out 1: 0 = PC, 1 = A.
- `aluSrcB` out 2: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `aluOp` out 2: 00 = add, 01 = sub, 10 = decode by funct.
- `pcSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcEn` out 1: PC load enable.
- `illegalOp` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug and bench.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States and their outputs. Any output not listed is 0, apart from the don't-care mux selects, which are driven to 0.
  - FETCH: memReq=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00. irWrite and pcWrite are asserted only while memReady=1. The state stays in FETCH until memReady=1, then goes to DECODE.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
    - lw and sw go to MEMADR.
    - R-type goes to EXECUTE.
    - beq goes to BRANCH.
    - addi goes to ADDIEXEC.
    - j goes to JUMP.
    - Any other opcode goes to FETCH, with illegalOp=1 for that DECODE cycle.
  - MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: memReq=1, iorD=1. The state holds until memReady=1, then goes to MEMWB.
  - MEMWB: regDst=0, memToReg=1, regWrite=1. Next state is FETCH.
  - MEMWR: memReq=1, iorD=1, memWrite=1. The state holds until memReady=1, then goes to FETCH.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Next state is ALUWB.
  - ALUWB: regDst=1, memToReg=0, regWrite=1. Next state is FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1. Next state is FETCH.
  - ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Next state is ADDIWB.
  - ADDIWB: regDst=0, memToReg=0, regWrite=1. Next state is FETCH.
  - JUMP: pcSrc=10, pcWrite=1. Next state is FETCH.
- pcEn = pcWrite | (branch & zero). This is combinational from the current state, memReady and zero; pcWrite and branch are internal signals.
- opcode is sampled only in DECODE and MEMADR. The IR is stable in those states.

## Timing
- reset=1 at a rising edge sets state to FETCH.
- While reset=1, all write-type outputs are forced to 0 combinationally: memReq, memWrite, irWrite, regWrite, pcEn. illegalOp is also forced to 0.
- Reset values of the remaining outputs are the FETCH encoding: iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00, state=FETCH.
- Reset asserted mid-instruction aborts the instruction at the next edge. No partial register write occurs after that edge.
- Cycle counts with memReady held high:
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - sw: 4
  - lw: 5
- Each cycle with memReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs hold steady during the stall.
- memWrite stays high for every cycle of MEMWR, including stall cycles. Memory must commit only on the cycle where memReady=1.
- All outputs are Moore outputs, except irWrite, pcEn and the FETCH-state pcWrite, which also depend on memReady and zero.

## Structure
- Package `mips_pkg` holds:
  - The state encoding: 4-bit enumeration FETCH=0 … JUMP=11; codes 12–15 are unused.
  - Opcode constants.
  - aluOp and pcSrc encoding constants. The existing ALU decoder also uses these.
- An unused state code recovers to FETCH on the next edge and outputs the FETCH encoding with write enables low.
- The block is a single module with no sub-modules. It is instantiated beside the ALU decoder in the top-level control wrapper.

## Test plan
- R-type add, memReady=1: state goes FETCH→DECODE→EXECUTE→ALUWB→FETCH. aluOp=10 in EXECUTE. regWrite=1 with regDst=1 only in ALUWB.
- lw with memReady low for 2 cycles in MEMRD: MEMRD lasts 3 cycles with iorD=1 and memReq=1 throughout. MEMWB has memToReg=1 and regWrite=1. Total is 7 cycles.
- beq with zero=1: pcEn=1 in BRANCH with pcSrc=01. Repeat with zero=0: pcEn=0 in BRANCH.
- opcode 111111: illegalOp=1 for exactly 1 cycle in DECODE. The next state is FETCH and no regWrite or memWrite is asserted.
- Assert reset during MEMWR while memReady=0: next state is FETCH, and memWrite and memReq drop to 0 immediately.
- FETCH with memReady=0 for 3 cycles: irWrite=0 and pcEn=0 during the stall. Both assert on the cycle memReady=1, and the next state is DECODE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: state codes, opcodes,
// mux-select encodings and the bundled control-word type.
package mips_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller.sv
// Moore main-control FSM for the multicycle MIPS datapath; memReady stretches
// the fetch and data-memory states, and pcEn folds in the branch zero flag.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       iorD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       illegalOp,
  output logic [3:0] state
);

  logic [3:0] state_d, state_q;
  ctrl_t      ctrl_s;
  logic       illegal_s;

  // Next-state and per-state control word.
  always_comb begin
    ctrl_s    = '0;
    illegal_s = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_req   = 1'b1;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.ir_write  = memReady;
        ctrl_s.pc_write  = memReady;
        if (memReady) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        if (opcode == OP_SW) state_d = S_MEMWR;
        else                 state_d = S_MEMRD;
      end
      S_MEMRD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
        if (memReady) state_d = S_MEMWB;
        else          state_d = S_MEMRD;
      end
      S_MEMWB: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe stays up through the stall; memory commits on memReady.
        ctrl_s.mem_req   = 1'b1;
        ctrl_s.iord      = 1'b1;
        ctrl_s.mem_write = 1'b1;
        if (memReady) state_d = S_FETCH;
        else          state_d = S_MEMWR;
      end
      S_EXECUTE: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_B;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_s.reg_dst   = 1'b1;
        ctrl_s.reg_write = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_B;
        ctrl_s.alu_op    = ALUOP_SUB;
        ctrl_s.pc_src    = PCSRC_ALUOUT;
        ctrl_s.branch    = 1'b1;
        state_d          = S_FETCH;
      end
      S_ADDIEXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        state_d          = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_s.reg_write = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_src   = PCSRC_JUMP;
        ctrl_s.pc_write = 1'b1;
        state_d         = S_FETCH;
      end
      default: begin
        // Unused codes look like FETCH with every enable low, then recover.
        ctrl_s.alu_src_b = SRCB_FOUR;
        state_d          = S_FETCH;
      end
    endcase
  end

  // Output drive; reset masks every write-type strobe combinationally.
  always_comb begin
    memReq    = ctrl_s.mem_req & ~reset;
    iorD      = ctrl_s.iord;
    memWrite  = ctrl_s.mem_write & ~reset;
    irWrite   = ctrl_s.ir_write & ~reset;
    regDst    = ctrl_s.reg_dst;
    memToReg  = ctrl_s.mem_to_reg;
    regWrite  = ctrl_s.reg_write & ~reset;
    aluSrcA   = ctrl_s.alu_src_a;
    aluSrcB   = ctrl_s.alu_src_b;
    aluOp     = ctrl_s.alu_op;
    pcSrc     = ctrl_s.pc_src;
    pcEn      = (ctrl_s.pc_write | (ctrl_s.branch & zero)) & ~reset;
    illegalOp = illegal_s & ~reset;
    state     = state_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule
